// File: rtl/axis_write_arbiter.sv
// rtl/axis_write_arbiter.sv - 2-to-1 round-robin AXI-Stream packet arbiter with beat-limit guard
// Grant is held per packet; a registered output stage feeds the memory_controller write port.
module axis_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_reset,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic [1:0]              grant,
  output logic                    forced_last
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT0, ST_GRANT1} state_t;

  state_t          r_state;
  logic            r_last_owner;
  logic [CW-1:0]   r_beat_cnt;
  logic [1:0]      r_grant;
  logic            r_forced_last;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [SW-1:0]   r_tstrb;
  logic            r_tvalid;
  logic            r_tlast;

  logic                  w_out_free;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic [SW-1:0]         w_sel_tstrb;
  logic                  w_sel_tlast;
  logic                  w_accept;
  logic                  w_cnt_end;
  logic                  w_end;

  // The output register can take a beat when empty or when it drains this cycle.
  assign w_out_free      = !r_tvalid | m00_axis_tready;
  assign s00_axis_tready = (r_state == ST_GRANT0) & w_out_free;
  assign s01_axis_tready = (r_state == ST_GRANT1) & w_out_free;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_tdata = s00_axis_tdata;
    w_sel_tstrb = s00_axis_tstrb;
    w_sel_tlast = s00_axis_tlast;
    if (r_state == ST_GRANT0) begin
      w_sel_valid = s00_axis_tvalid;
    end else if (r_state == ST_GRANT1) begin
      w_sel_valid = s01_axis_tvalid;
      w_sel_tdata = s01_axis_tdata;
      w_sel_tstrb = s01_axis_tstrb;
      w_sel_tlast = s01_axis_tlast;
    end
  end

  assign w_accept  = (s00_axis_tvalid & s00_axis_tready) | (s01_axis_tvalid & s01_axis_tready);
  assign w_cnt_end = (r_beat_cnt == CW'(MAX_BEATS - 1));
  assign w_end     = w_sel_tlast | w_cnt_end;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_state       <= ST_IDLE;
      r_last_owner  <= 1'b1;
      r_beat_cnt    <= '0;
      r_grant       <= 2'b00;
      r_forced_last <= 1'b0;
      r_tdata       <= '0;
      r_tstrb       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
    end else begin
      r_forced_last <= 1'b0;
      if (w_accept) begin
        r_tdata  <= w_sel_tdata;
        r_tstrb  <= w_sel_tstrb;
        r_tvalid <= 1'b1;
        r_tlast  <= w_end;
      end else if (m00_axis_tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          // On a tie the port that did not own the last packet wins.
          if (s00_axis_tvalid && (!s01_axis_tvalid || r_last_owner)) begin
            r_state <= ST_GRANT0;
            r_grant <= 2'b01;
          end else if (s01_axis_tvalid) begin
            r_state <= ST_GRANT1;
            r_grant <= 2'b10;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (w_accept) begin
            if (w_end) begin
              r_beat_cnt    <= '0;
              r_state       <= ST_IDLE;
              r_grant       <= 2'b00;
              r_last_owner  <= (r_state == ST_GRANT1);
              r_forced_last <= !w_sel_tlast;
            end else begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = r_tstrb;
  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tlast  = r_tlast;
  assign grant           = r_grant;
  assign forced_last     = r_forced_last;

endmodule

// File: tb/tb_axis_write_arbiter.sv
// tb/tb_axis_write_arbiter.sv - directed self-checking bench for axis_write_arbiter
// Sources are queue-driven AXI-Stream masters; outputs are recorded on the falling edge.
module tb_axis_write_arbiter;
  logic        clk;
  logic        axis_reset;
  logic [31:0] s00_axis_tdata, s01_axis_tdata, m00_axis_tdata;
  logic [3:0]  s00_axis_tstrb, s01_axis_tstrb, m00_axis_tstrb;
  logic        s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic        s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
  logic [1:0]  grant;
  logic        forced_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0_data[$], q1_data[$];
  logic        q0_last[$], q1_last[$];
  logic        rdy_q[$];
  logic [31:0] mon_data[$];
  logic [3:0]  mon_strb[$];
  logic        mon_last[$];
  logic [1:0]  grant_hist[$];
  logic [31:0] data_hist[$];
  int          forced_cnt;

  axis_write_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(16)) dut (
    .axis_aclk(clk), .axis_reset(axis_reset),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tstrb(s00_axis_tstrb),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tstrb(s01_axis_tstrb),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tready(s01_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .grant(grant), .forced_last(forced_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_inputs();
    s00_axis_tvalid = (q0_data.size() > 0);
    s00_axis_tdata  = (q0_data.size() > 0) ? q0_data[0] : 32'h0;
    s00_axis_tlast  = (q0_data.size() > 0) ? q0_last[0] : 1'b0;
    s00_axis_tstrb  = s00_axis_tdata[3:0];
    s01_axis_tvalid = (q1_data.size() > 0);
    s01_axis_tdata  = (q1_data.size() > 0) ? q1_data[0] : 32'h0;
    s01_axis_tlast  = (q1_data.size() > 0) ? q1_last[0] : 1'b0;
    s01_axis_tstrb  = s01_axis_tdata[3:0];
    m00_axis_tready = (rdy_q.size() > 0) ? rdy_q[0] : 1'b1;
  endtask

  task automatic clear_all();
    q0_data.delete(); q0_last.delete(); q1_data.delete(); q1_last.delete(); rdy_q.delete();
  endtask

  task automatic do_reset(input int n);
    axis_reset = 1'b1;
    clear_all();
    drive_inputs();
    repeat (n) @(posedge clk);
    #1 axis_reset = 1'b0;
  endtask

  // Called just after a rising edge; each iteration is one clock cycle.
  task automatic run(input int max_cycles, output bit done);
    bit f0, f1;
    done = 1'b0;
    mon_data.delete(); mon_strb.delete(); mon_last.delete();
    grant_hist.delete(); data_hist.delete(); forced_cnt = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      drive_inputs();
      @(negedge clk);
      f0 = s00_axis_tvalid && s00_axis_tready;
      f1 = s01_axis_tvalid && s01_axis_tready;
      grant_hist.push_back(grant);
      data_hist.push_back(m00_axis_tdata);
      if (forced_last) forced_cnt++;
      if (m00_axis_tvalid && m00_axis_tready) begin
        mon_data.push_back(m00_axis_tdata);
        mon_strb.push_back(m00_axis_tstrb);
        mon_last.push_back(m00_axis_tlast);
      end
      @(posedge clk);
      #1;
      if (f0) begin void'(q0_data.pop_front()); void'(q0_last.pop_front()); end
      if (f1) begin void'(q1_data.pop_front()); void'(q1_last.pop_front()); end
      if (rdy_q.size() > 0) void'(rdy_q.pop_front());
      if (q0_data.size() == 0 && q1_data.size() == 0 && !m00_axis_tvalid) done = 1'b1;
    end
    drive_inputs();
  endtask

  task automatic test_reset();
    axis_reset = 1'b1;
    clear_all();
    drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m00_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b exp 0", m00_axis_tvalid); end
    n_checks++; if (m00_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL rst_tdata got %h exp 0", m00_axis_tdata); end
    n_checks++; if (m00_axis_tstrb !== 4'h0) begin n_fail++; $display("FAIL rst_tstrb got %h exp 0", m00_axis_tstrb); end
    n_checks++; if (m00_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b exp 0", m00_axis_tlast); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant got %b exp 00", grant); end
    n_checks++; if (forced_last !== 1'b0) begin n_fail++; $display("FAIL rst_forced got %b exp 0", forced_last); end
    @(posedge clk);
    #1 axis_reset = 1'b0;
    @(negedge clk);
    n_checks++; if (s00_axis_tready !== 1'b0 || s01_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL idle_tready got %b%b exp 00", s00_axis_tready, s01_axis_tready); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL idle_grant got %b exp 00", grant); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_packet();
    logic [31:0] exp_d [3];
    logic        exp_l [3];
    bit done;
    exp_d = '{32'h55, 32'h22, 32'h24};
    exp_l = '{1'b0, 1'b0, 1'b1};
    do_reset(2);
    for (int i = 0; i < 3; i++) begin q0_data.push_back(exp_d[i]); q0_last.push_back(exp_l[i]); end
    run(40, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL t2_timeout got 0 exp 1"); end
    n_checks++; if (mon_data.size() != 3) begin n_fail++; $display("FAIL t2_count got %0d exp 3", mon_data.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (mon_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL t2_data[%0d] got %h exp %h", i, mon_data[i], exp_d[i]); end
      n_checks++; if (mon_last[i] !== exp_l[i]) begin n_fail++; $display("FAIL t2_last[%0d] got %b exp %b", i, mon_last[i], exp_l[i]); end
      n_checks++; if (mon_strb[i] !== exp_d[i][3:0]) begin n_fail++; $display("FAIL t2_strb[%0d] got %h exp %h", i, mon_strb[i], exp_d[i][3:0]); end
    end
    n_checks++; if (grant_hist[1] !== 2'b01) begin n_fail++; $display("FAIL t2_grant_on got %b exp 01", grant_hist[1]); end
    n_checks++; if (grant_hist[3] !== 2'b01) begin n_fail++; $display("FAIL t2_grant_held got %b exp 01", grant_hist[3]); end
    n_checks++; if (grant_hist[4] !== 2'b00) begin n_fail++; $display("FAIL t2_grant_off got %b exp 00", grant_hist[4]); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [8];
    bit done;
    exp_d = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hA3, 32'hB2, 32'hB3};
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      q0_data.push_back(32'hA0 + i); q0_last.push_back(i[0]);
      q1_data.push_back(32'hB0 + i); q1_last.push_back(i[0]);
    end
    run(60, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL t3_timeout got 0 exp 1"); end
    n_checks++; if (mon_data.size() != 8) begin n_fail++; $display("FAIL t3_count got %0d exp 8", mon_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (mon_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL t3_data[%0d] got %h exp %h", i, mon_data[i], exp_d[i]); end
      n_checks++; if (mon_last[i] !== exp_d[i][0]) begin n_fail++; $display("FAIL t3_last[%0d] got %b exp %b", i, mon_last[i], exp_d[i][0]); end
    end
  endtask

  task automatic test_forced_last();
    bit done;
    logic exp_l;
    do_reset(2);
    for (int i = 0; i < 20; i++) begin q1_data.push_back(32'h100 + i); q1_last.push_back(1'b0); end
    run(100, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL t4_timeout got 0 exp 1"); end
    n_checks++; if (mon_data.size() != 20) begin n_fail++; $display("FAIL t4_count got %0d exp 20", mon_data.size()); end
    for (int i = 0; i < 20; i++) begin
      exp_l = (i == 15);
      n_checks++; if (mon_data[i] !== 32'h100 + i) begin n_fail++; $display("FAIL t4_data[%0d] got %h exp %h", i, mon_data[i], 32'h100 + i); end
      n_checks++; if (mon_last[i] !== exp_l) begin n_fail++; $display("FAIL t4_last[%0d] got %b exp %b", i, mon_last[i], exp_l); end
    end
    n_checks++; if (forced_cnt != 1) begin n_fail++; $display("FAIL t4_forced_pulses got %0d exp 1", forced_cnt); end
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL t4_regrant got %b exp 10", grant); end
  endtask

  task automatic test_backpressure();
    bit done;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin q0_data.push_back(32'hC1 + i); q0_last.push_back(i == 3); end
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run(40, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL t5_timeout got 0 exp 1"); end
    n_checks++; if (data_hist[2] !== 32'hC1) begin n_fail++; $display("FAIL t5_first got %h exp c1", data_hist[2]); end
    for (int c = 3; c < 6; c++) begin
      n_checks++; if (data_hist[c] !== 32'hC2) begin n_fail++; $display("FAIL t5_stall[%0d] got %h exp c2", c, data_hist[c]); end
    end
    n_checks++; if (mon_data.size() != 4) begin n_fail++; $display("FAIL t5_count got %0d exp 4", mon_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mon_data[i] !== 32'hC1 + i) begin n_fail++; $display("FAIL t5_data[%0d] got %h exp %h", i, mon_data[i], 32'hC1 + i); end
    end
  endtask

  task automatic test_mid_packet_reset();
    bit done;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin q0_data.push_back(32'hD1 + i); q0_last.push_back(i == 3); end
    run(3, done);
    axis_reset = 1'b1;
    q1_data.push_back(32'hE1); q1_last.push_back(1'b1);
    drive_inputs();
    @(posedge clk);
    #1 axis_reset = 1'b0;
    n_checks++; if (m00_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL t6_tvalid got %b exp 0", m00_axis_tvalid); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL t6_grant got %b exp 00", grant); end
    n_checks++; if (s00_axis_tready !== 1'b0 || s01_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL t6_idle_tready got %b%b exp 00", s00_axis_tready, s01_axis_tready); end
    run(40, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL t6_timeout got 0 exp 1"); end
    n_checks++; if (grant_hist[1] !== 2'b01) begin n_fail++; $display("FAIL t6_tie_grant got %b exp 01", grant_hist[1]); end
    n_checks++; if (mon_data.size() != 3) begin n_fail++; $display("FAIL t6_count got %0d exp 3", mon_data.size()); end
    n_checks++; if (mon_data[0] !== 32'hD3) begin n_fail++; $display("FAIL t6_data0 got %h exp d3", mon_data[0]); end
    n_checks++; if (mon_data[1] !== 32'hD4 || mon_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL t6_data1 got %h/%b exp d4/1", mon_data[1], mon_last[1]); end
    n_checks++; if (mon_data[2] !== 32'hE1) begin n_fail++; $display("FAIL t6_data2 got %h exp e1", mon_data[2]); end
  endtask

  initial begin
    axis_reset = 1'b1;
    clear_all();
    drive_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_forced_last();
    test_backpressure();
    test_mid_packet_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
